// File: rtl/load_store_pkg.sv
// load_store_pkg: shared types and constants for the data-memory load/save paths.
package load_store_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE2, S_WAIT, S_DONE, S_HOLD} load_state_t;
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_OP1  = 2'd1;
   localparam logic [1:0] TAG_OP2  = 2'd2;
   function automatic int addr_width(input int mem_size);
      return $clog2(mem_size);
   endfunction
endpackage

// File: rtl/read_return_tracker.sv
// read_return_tracker: delays read tags by the memory latency so each tag exits with its data.
module read_return_tracker #(
   parameter int READ_LATENCY = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_flush,
   input  logic [1:0] i_tag,
   output logic [1:0] o_exit_tag
);
   logic [READ_LATENCY-1:0][1:0] r_sr;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) r_sr <= '0;
      else begin
         r_sr[0] <= i_tag;
         for (int k = 1; k < READ_LATENCY; k++) r_sr[k] <= r_sr[k-1];
      end
   end
   assign o_exit_tag = r_sr[READ_LATENCY-1];
endmodule

// File: rtl/load_handler.sv
// load_handler: fetches two operands from a synchronous-read data memory and
// presents them with a one-cycle ready pulse.
module load_handler
   import load_store_pkg::*;
#(
   parameter int DATA_WIDTH        = 8,
   parameter int DATA_MEMORY_SIZE  = 64,
   parameter int ADDR_WIDTH        = addr_width(DATA_MEMORY_SIZE),
   parameter int INSTRUCTION_WIDTH = 3*$clog2(DATA_MEMORY_SIZE)+2,
   parameter int READ_LATENCY      = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic [ADDR_WIDTH-1:0] i_src1_addr,
   input  logic [ADDR_WIDTH-1:0] i_src2_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_data_in,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_rd_en,
   output logic [DATA_WIDTH-1:0] o_operand1,
   output logic [DATA_WIDTH-1:0] o_operand2,
   output logic                  o_ready
);
   if (READ_LATENCY < 1 || READ_LATENCY > 4 || INSTRUCTION_WIDTH < 1) begin : g_bad_cfg
      $error("load_handler: READ_LATENCY must be 1..4");
   end
   load_state_t           r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_mem_addr, r_src2, w_addr;
   logic [DATA_WIDTH-1:0] r_stage1, r_op1, r_op2;
   logic [1:0]            r_tag, w_tag, w_exit;
   logic                  r_rd_en, r_ready, w_rd_en, w_flush, w_latch, w_cap1, w_commit;
   // The issued tag is registered alongside the address so it enters the
   // tracker in the same cycle the memory samples that address.
   read_return_tracker #(.READ_LATENCY(READ_LATENCY)) u_tracker (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (w_flush),
      .i_tag      (r_tag),
      .o_exit_tag (w_exit)
   );
   always_comb begin
      w_next   = r_state;
      w_addr   = r_mem_addr;
      w_rd_en  = 1'b0;
      w_tag    = TAG_NONE;
      w_flush  = 1'b0;
      w_latch  = 1'b0;
      w_cap1   = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         S_IDLE: if (i_enable) begin
            w_next  = S_ISSUE2;
            w_addr  = i_src1_addr;
            w_rd_en = 1'b1;
            w_tag   = TAG_OP1;
            w_latch = 1'b1;
         end
         S_ISSUE2: if (!i_enable) begin
            w_next  = S_IDLE;
            w_flush = 1'b1;
         end else begin
            w_next  = S_WAIT;
            w_addr  = r_src2;
            w_rd_en = 1'b1;
            w_tag   = TAG_OP2;
         end
         S_WAIT: if (!i_enable) begin
            w_next  = S_IDLE;
            w_flush = 1'b1;
         end else begin
            w_cap1   = w_exit == TAG_OP1;
            w_commit = w_exit == TAG_OP2;
            w_next   = w_commit ? S_DONE : S_WAIT;
         end
         S_DONE:  w_next = i_enable ? S_HOLD : S_IDLE;
         S_HOLD:  w_next = i_enable ? S_HOLD : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_mem_addr <= '0;
         r_rd_en    <= 1'b0;
         r_tag      <= TAG_NONE;
         r_ready    <= 1'b0;
         r_src2     <= '0;
         r_stage1   <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
      end else begin
         r_state    <= w_next;
         r_mem_addr <= w_addr;
         r_rd_en    <= w_rd_en;
         r_tag      <= w_tag;
         r_ready    <= w_commit;
         if (w_latch) r_src2 <= i_src2_addr;
         if (w_cap1) r_stage1 <= i_mem_data_in;
         if (w_commit) begin
            r_op1 <= r_stage1;
            r_op2 <= i_mem_data_in;
         end
      end
   end
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_rd_en = r_rd_en;
   assign o_operand1  = r_op1;
   assign o_operand2  = r_op2;
   assign o_ready     = r_ready;
endmodule
